bus_stall_ctrl: RTL and testbench

Single-clock CPU bus stall controller that decodes CPU transactions into `NUM_CH` peripheral channels by address window, forwards writes as one-cycle strobes, and halts the CPU through `busy_o` while a read is outstanding. Channels may return read data after any number of cycles. An optional timeout terminates hung reads with a fixed error word. It sits between the `bus_rv32` CPU side and slow or variable-latency peripherals in the CPU clock domain. It is the parametrised successor to the per-region read-halt logic of the CDC bridge.

---
 rtl/bus_stall_ctrl_pkg.sv | 59 +++++
 rtl/bus_stall_ctrl_timeout_counter.sv | 33 +++
 rtl/bus_stall_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bus_stall_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_stall_ctrl_pkg.sv
// Shared types and the address-window helper for the CPU bus stall controller.
// The helper works on maximum-size vectors so it can stay a plain package
// function; callers zero-extend their parameters into MAX_CH x MAX_AW slots.
package cpu_reg_package;

    localparam int MAX_CH = 16;
    localparam int MAX_AW = 64;
    localparam int MAX_DW = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } bus_stall_state_t;

    typedef struct packed {
        logic              we;
        logic [MAX_AW-1:0] address;
        logic [MAX_DW-1:0] data;
    } bus_req_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] ch;
    } win_match_t;

    // Windows are packed with stride aw; lowest matching channel wins.
    function automatic win_match_t find_window(
        input logic [MAX_CH*MAX_AW-1:0] base,
        input logic [MAX_CH*MAX_AW-1:0] limit,
        input logic [MAX_AW-1:0]        addr,
        input int                       num_ch,
        input int                       aw
    );
        win_match_t                m;
        logic [MAX_AW-1:0]         mask;
        logic [MAX_AW-1:0]         b;
        logic [MAX_AW-1:0]         l;
        logic [MAX_CH*MAX_AW-1:0]  tb;
        logic [MAX_CH*MAX_AW-1:0]  tl;
        m    = '0;
        mask = ~({MAX_AW{1'b1}} << aw);
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < num_ch) begin
                tb = base >> (k * aw);
                tl = limit >> (k * aw);
                b  = tb[MAX_AW-1:0] & mask;
                l  = tl[MAX_AW-1:0] & mask;
                if (addr >= b && addr <= l) begin
                    m.hit = 1'b1;
                    m.ch  = 4'(k);
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_stall_ctrl_timeout_counter.sv
// Wait-cycle counter for aborting hung reads. Only compiled when
// BUS_STALL_TIMEOUT_EN is defined; the controller instantiates it under the
// same macro.
`ifdef BUS_STALL_TIMEOUT_EN
module bus_timeout_counter #(
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [CNT_W-1:0] count_q;

    // Expiry on the TIMEOUT_CYCLES-th enabled cycle after a clear.
    assign expire_o = enable_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count enabled cycles, holding at expiry so the count never wraps.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expire_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/bus_stall_ctrl.sv
// CPU bus stall controller: decodes CPU accesses into NUM_CH windows, forwards
// writes as one-cycle strobes and halts the CPU with busy_o while a read is
// outstanding. Optional read timeout under macro BUS_STALL_TIMEOUT_EN.
module bus_stall_ctrl
    import cpu_reg_package::*;
#(
    parameter int                       NUM_CH         = 4,
    parameter int                       ADDR_W         = 32,
    parameter int                       DATA_W         = 32,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE        = '0,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_LIMIT       = '0,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]        TIMEOUT_DATA   = DATA_W'(32'hDEADBEEF),
    localparam int                      CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        address_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    output logic [NUM_CH-1:0]        ch_valid_o,
    output logic                     ch_we_o,
    output logic [ADDR_W-1:0]        ch_address_o,
    output logic [DATA_W-1:0]        ch_wdata_o,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata_i,
    input  logic [NUM_CH-1:0]        ch_rvalid_i,
    output logic                     err_o,
    output logic [CH_W-1:0]          err_ch_o,
    input  logic                     err_clr_i
);

    localparam logic [MAX_CH*MAX_AW-1:0] BASE_EXT  = (MAX_CH*MAX_AW)'(CH_BASE);
    localparam logic [MAX_CH*MAX_AW-1:0] LIMIT_EXT = (MAX_CH*MAX_AW)'(CH_LIMIT);

    bus_stall_state_t  state_q;
    bus_stall_state_t  state_d;
    logic [ADDR_W-1:0] addr_q;
    bus_req_t          cur_req;
    win_match_t        match;
    logic [CH_W-1:0]   hit_ch;
    logic [CH_W-1:0]   cur_ch_q;
    logic              detect;
    logic              rvalid_hit;
    logic              timeout_hit;
    logic [DATA_W-1:0] rsel;
    logic              unused_sink;

    // Bundle the CPU request and look up its window.
    always_comb begin
        cur_req         = '0;
        cur_req.we      = we_i;
        cur_req.address = MAX_AW'(address_i);
        cur_req.data    = MAX_DW'(wdata_i);
        match           = find_window(BASE_EXT, LIMIT_EXT, cur_req.address, NUM_CH, ADDR_W);
    end

    assign hit_ch     = match.ch[CH_W-1:0];
    assign detect     = !reset_i && (state_q == IDLE) && (address_i != addr_q) && match.hit;
    assign rvalid_hit = (state_q == WAIT) && ch_rvalid_i[cur_ch_q];
    assign rsel       = ch_rdata_i[cur_ch_q*DATA_W +: DATA_W];

`ifdef BUS_STALL_TIMEOUT_EN
    logic expire;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (state_q == ISSUE),
        .enable_i(state_q == WAIT),
        .expire_o(expire)
    );

    assign timeout_hit = expire && !rvalid_hit;

    // Sticky error flag; a timeout in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_o    <= 1'b0;
            err_ch_o <= '0;
        end else if (timeout_hit) begin
            err_o    <= 1'b1;
            err_ch_o <= cur_ch_q;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

    assign unused_sink = ^{cur_req, match};
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
    assign err_ch_o    = '0;
    assign unused_sink = ^{cur_req, match, err_clr_i, TIMEOUT_DATA, TIMEOUT_CYCLES};
`endif

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and CPU halt; busy rises combinationally on a detected read.
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (detect && !cur_req.we) begin
                    state_d = ISSUE;
                    busy_o  = 1'b1;
                end
            end
            ISSUE: begin
                busy_o  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy_o = 1'b1;
                if (rvalid_hit || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address history, channel strobes and read-data capture.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q       <= '0;
            ch_valid_o   <= '0;
            ch_we_o      <= 1'b0;
            ch_address_o <= '0;
            ch_wdata_o   <= '0;
            cur_ch_q     <= '0;
            rdata_o      <= '0;
        end else begin
            addr_q     <= address_i;
            ch_valid_o <= '0;
            if (detect) begin
                ch_valid_o   <= NUM_CH'(1) << hit_ch;
                ch_we_o      <= cur_req.we;
                ch_address_o <= cur_req.address[ADDR_W-1:0];
                ch_wdata_o   <= cur_req.data[DATA_W-1:0];
                cur_ch_q     <= hit_ch;
            end
            if (rvalid_hit) begin
                rdata_o <= rsel;
            end else if (timeout_hit) begin
                rdata_o <= TIMEOUT_DATA;
            end
        end
    end

endmodule

// File: tb/tb_bus_stall_ctrl.sv
// Directed bench for bus_stall_ctrl: a vector table for writes, reads and
// decode corner cases, then hand sequences for timeout (BUS_STALL_TIMEOUT_EN)
// or the no-timeout build, and asynchronous reset during a read.
module tb_bus_stall_ctrl;

    localparam int NUM_CH = 4;
    localparam int AW     = 32;
    localparam int DW     = 32;

    logic                 clk;
    logic                 reset;
    logic                 we;
    logic [AW-1:0]        address;
    logic [DW-1:0]        wdata;
    logic [DW-1:0]        rdata;
    logic                 busy;
    logic [NUM_CH-1:0]    ch_valid;
    logic                 ch_we;
    logic [AW-1:0]        ch_address;
    logic [DW-1:0]        ch_wdata;
    logic [NUM_CH*DW-1:0] ch_rdata;
    logic [NUM_CH-1:0]    ch_rvalid;
    logic                 err;
    logic [1:0]           err_ch;
    logic                 err_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rvalid;
        int          rd_ch;
        logic [31:0] rd_word;
        logic        exp_busy;
        logic [3:0]  exp_valid;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    bus_stall_ctrl #(
        .NUM_CH        (NUM_CH),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .CH_BASE       ({32'h0000_3080, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000}),
        .CH_LIMIT      ({32'h0000_40FF, 32'h0000_30FF, 32'h0000_20FF, 32'h0000_10FF}),
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_DATA  (32'hDEADBEEF)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .we_i        (we),
        .address_i   (address),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .ch_valid_o  (ch_valid),
        .ch_we_o     (ch_we),
        .ch_address_o(ch_address),
        .ch_wdata_o  (ch_wdata),
        .ch_rdata_i  (ch_rdata),
        .ch_rvalid_i (ch_rvalid),
        .err_o       (err),
        .err_ch_o    (err_ch),
        .err_clr_i   (err_clr)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NUM_CH*DW-1:0] make_rd(input int k, input logic [31:0] w);
        logic [NUM_CH*DW-1:0] r;
        for (int j = 0; j < NUM_CH; j++) begin
            r[j*DW +: DW] = (j == k) ? w : (32'hF000_0000 | 32'(j));
        end
        return r;
    endfunction

    function automatic void add_vec(
        input logic we_v, input logic [31:0] addr_v, input logic [31:0] wd_v,
        input logic [3:0] rv_v, input int rch_v, input logic [31:0] rw_v,
        input logic busy_v, input logic [3:0] val_v, input logic ewe_v,
        input logic [31:0] eaddr_v, input logic [31:0] ewd_v, input logic [31:0] erd_v
    );
        vec_t v;
        v.we = we_v;   v.addr = addr_v;   v.wdata = wd_v;
        v.rvalid = rv_v; v.rd_ch = rch_v; v.rd_word = rw_v;
        v.exp_busy = busy_v; v.exp_valid = val_v; v.exp_we = ewe_v;
        v.exp_addr = eaddr_v; v.exp_wdata = ewd_v; v.exp_rdata = erd_v;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then let them settle.
    task automatic drive(input logic we_v, input logic [31:0] addr_v, input logic [31:0] wd_v,
                         input logic [3:0] rv_v, input int rch_v, input logic [31:0] rw_v,
                         input logic clr_v);
        @(negedge clk);
        we        = we_v;
        address   = addr_v;
        wdata     = wd_v;
        ch_rvalid = rv_v;
        ch_rdata  = make_rd(rch_v, rw_v);
        err_clr   = clr_v;
        #2;
    endtask

    task automatic apply_stimulus(input vec_t v);
        drive(v.we, v.addr, v.wdata, v.rvalid, v.rd_ch, v.rd_word, 1'b0);
    endtask

    initial begin
        int  busy_cnt;
        bit  done;

        reset = 1'b1; we = 1'b0; address = '0; wdata = '0;
        ch_rvalid = '0; ch_rdata = '0; err_clr = 1'b0;

        // Vector table: we, addr, wdata, rvalid, rd_ch, rd_word | busy, valid, we, addr, wdata, rdata
        add_vec(0, 32'h0,    32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h0);
        add_vec(1, 32'h3004, 32'h1234, 4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h0);
        add_vec(0, 32'h3004, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0100, 1, 32'h3004, 32'h1234, 32'h0);
        add_vec(0, 32'h3004, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h0);
        add_vec(0, 32'h2010, 32'h0,    4'b0000, 0, 32'h0, 1, 4'b0000, 0, 0, 0, 32'h0);
        add_vec(0, 32'h2010, 32'h0,    4'b0000, 0, 32'h0, 1, 4'b0010, 0, 32'h2010, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            add_vec(0, 32'h2010, 32'h0, 4'b0000, 0, 32'h0, 1, 4'b0000, 0, 0, 0, 32'h0);
        add_vec(0, 32'h2010, 32'h0,    4'b0010, 1, 32'hA5A5A5A5, 1, 4'b0000, 0, 0, 0, 32'h0);
        add_vec(0, 32'h2010, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h2010, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h2010, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h5000, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h5000, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h3008, 32'h0,    4'b0000, 0, 32'h0, 1, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h3008, 32'h0,    4'b0000, 0, 32'h0, 1, 4'b0100, 0, 32'h3008, 32'h0, 32'hA5A5A5A5);
        add_vec(0, 32'h3008, 32'h0,    4'b0001, 0, 32'h11111111, 1, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h3008, 32'h0,    4'b0000, 0, 32'h0, 1, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h3008, 32'h0,    4'b0100, 2, 32'h55, 1, 4'b0000, 0, 0, 0, 32'hA5A5A5A5);
        add_vec(0, 32'h3008, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h55);
        add_vec(1, 32'h3090, 32'hCAFE, 4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h55);
        add_vec(0, 32'h3090, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0100, 1, 32'h3090, 32'hCAFE, 32'h55);
        add_vec(0, 32'h1004, 32'h0,    4'b0000, 0, 32'h0, 1, 4'b0000, 0, 0, 0, 32'h55);
        add_vec(0, 32'h1004, 32'h0,    4'b0000, 0, 32'h0, 1, 4'b0001, 0, 32'h1004, 32'h0, 32'h55);
        add_vec(0, 32'h1004, 32'h0,    4'b0001, 0, 32'h77, 1, 4'b0000, 0, 0, 0, 32'h55);
        add_vec(0, 32'h1004, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h77);
        add_vec(0, 32'h1004, 32'h0,    4'b0000, 0, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h77);

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check_output("rst busy",     32'(busy),     32'h0);
        check_output("rst rdata",    rdata,         32'h0);
        check_output("rst ch_valid", 32'(ch_valid), 32'h0);
        check_output("rst ch_we",    32'(ch_we),    32'h0);
        check_output("rst ch_addr",  ch_address,    32'h0);
        check_output("rst ch_wdata", ch_wdata,      32'h0);
        check_output("rst err",      32'(err),      32'h0);
        check_output("rst err_ch",   32'(err_ch),   32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].exp_busy));
            check_output($sformatf("v%0d ch_valid", i), 32'(ch_valid), 32'(vecs[i].exp_valid));
            check_output($sformatf("v%0d rdata", i),    rdata,         vecs[i].exp_rdata);
            check_output($sformatf("v%0d err", i),      32'(err),      32'h0);
            if (vecs[i].exp_valid != 4'b0000) begin
                check_output($sformatf("v%0d ch_we", i),    32'(ch_we), 32'(vecs[i].exp_we));
                check_output($sformatf("v%0d ch_addr", i),  ch_address, vecs[i].exp_addr);
                check_output($sformatf("v%0d ch_wdata", i), ch_wdata,   vecs[i].exp_wdata);
            end
        end

`ifdef BUS_STALL_TIMEOUT_EN
        // Unanswered read of ch3: busy for 10 cycles, then the error word.
        drive(0, 32'h4010, 0, 4'b0000, 0, 0, 0);
        busy_cnt = 0;
        done     = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 1) check_output("to ch_valid", 32'(ch_valid), 32'h8);
            if (busy) begin
                busy_cnt++;
                drive(0, 32'h4010, 0, 4'b0000, 0, 0, 0);
            end else begin
                done = 1;
            end
        end
        check_output("to finished", 32'(done), 32'h1);
        check_output("to busy cycles", 32'(busy_cnt), 32'd10);
        check_output("to rdata",  rdata,        32'hDEADBEEF);
        check_output("to err",    32'(err),     32'h1);
        check_output("to err_ch", 32'(err_ch),  32'h3);
        drive(0, 32'h4010, 0, 4'b0000, 0, 0, 1);
        check_output("clr err before edge", 32'(err), 32'h1);
        drive(0, 32'h4010, 0, 4'b0000, 0, 0, 0);
        check_output("clr err", 32'(err), 32'h0);
        check_output("clr err_ch kept", 32'(err_ch), 32'h3);

        // Response in the last wait cycle beats the timeout.
        drive(0, 32'h4020, 0, 4'b0000, 0, 0, 0);
        for (int c = 1; c <= 8; c++) drive(0, 32'h4020, 0, 4'b0000, 0, 0, 0);
        drive(0, 32'h4020, 0, 4'b1000, 3, 32'h99, 0);
        drive(0, 32'h4020, 0, 4'b0000, 0, 0, 0);
        check_output("race busy",  32'(busy), 32'h0);
        check_output("race rdata", rdata,     32'h99);
        check_output("race err",   32'(err),  32'h0);

        // Timeout coinciding with a clear leaves the flag set.
        drive(0, 32'h4030, 0, 4'b0000, 0, 0, 0);
        for (int c = 1; c <= 8; c++) drive(0, 32'h4030, 0, 4'b0000, 0, 0, 0);
        drive(0, 32'h4030, 0, 4'b0000, 0, 0, 1);
        drive(0, 32'h4030, 0, 4'b0000, 0, 0, 0);
        check_output("setclr busy",  32'(busy), 32'h0);
        check_output("setclr err",   32'(err),  32'h1);
        check_output("setclr rdata", rdata,     32'hDEADBEEF);
`else
        // Without the timeout a hung read stalls until its channel answers.
        drive(0, 32'h4010, 0, 4'b0000, 0, 0, 0);
        busy_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (busy) busy_cnt++;
            drive(0, 32'h4010, 0, 4'b0000, 0, 0, 1);
        end
        check_output("hang busy cycles", 32'(busy_cnt), 32'd30);
        check_output("hang err",    32'(err),    32'h0);
        check_output("hang err_ch", 32'(err_ch), 32'h0);
        drive(0, 32'h4010, 0, 4'b1000, 3, 32'h33, 0);
        drive(0, 32'h4010, 0, 4'b0000, 0, 0, 0);
        check_output("hang busy",  32'(busy), 32'h0);
        check_output("hang rdata", rdata,     32'h33);
`endif

        // Asynchronous reset while waiting on ch1, then a late response.
        drive(0, 32'h2020, 0, 4'b0000, 0, 0, 0);
        drive(0, 32'h2020, 0, 4'b0000, 0, 0, 0);
        drive(0, 32'h2020, 0, 4'b0000, 0, 0, 0);
        check_output("pre-rst busy", 32'(busy), 32'h1);
        @(negedge clk);
        reset   = 1'b1;
        address = 32'h5000;
        #2;
        check_output("mid-rst busy",     32'(busy),     32'h0);
        check_output("mid-rst rdata",    rdata,         32'h0);
        check_output("mid-rst ch_valid", 32'(ch_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 32'h5000, 0, 4'b0010, 1, 32'hBEEF, 0);
        check_output("late busy", 32'(busy), 32'h0);
        drive(0, 32'h5000, 0, 4'b0000, 0, 0, 0);
        check_output("late rdata",    rdata,         32'h0);
        check_output("late ch_valid", 32'(ch_valid), 32'h0);

        // FSM is back in IDLE: a fresh read is accepted normally.
        drive(0, 32'h2030, 0, 4'b0000, 0, 0, 0);
        check_output("post busy0", 32'(busy), 32'h1);
        drive(0, 32'h2030, 0, 4'b0000, 0, 0, 0);
        check_output("post ch_valid", 32'(ch_valid), 32'h2);
        drive(0, 32'h2030, 0, 4'b0010, 1, 32'h42, 0);
        drive(0, 32'h2030, 0, 4'b0000, 0, 0, 0);
        check_output("post busy3", 32'(busy), 32'h0);
        check_output("post rdata", rdata,     32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
